mem_access_arbiter: RTL

Shares the single MAR/MBR/MFA memory port between two requesters: instruction fetch (F) and data load/store (D). It latches the winning request, drives MARLOAD/MBRLOAD, holds MFA until MFC, returns read data and a one-cycle done pulse to the owner. The control unit uses it in place of driving MFA/READ_WRITE/WORD_BYTE directly. A watchdog aborts transactions whose MFC never arrives.

---
 rtl/mem_access_arbiter.sv | 179 +++++++++++++++++
 1 files changed

// File: rtl/mem_access_arbiter.sv
// ============================================================================
// Module  : mem_access_arbiter
// Brief   : Shares the MAR/MBR/MFA memory port between fetch (F) and data (D)
//           requesters, with D-streak fairness and an MFC watchdog.
// Revision: 1.0
// ============================================================================
`default_nettype none

module mem_access_arbiter #(
  parameter int TIMEOUT      = 16,
  parameter int MAX_D_STREAK = 4
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        f_req,
  input  logic [31:0] f_addr,
  input  logic        d_req,
  input  logic        d_rw,
  input  logic        d_word_byte,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic        f_done,
  output logic        d_done,
  output logic [31:0] rdata,
  output logic        err,
  output logic        busy,
  output logic [31:0] mar_out,
  output logic [31:0] mbr_out,
  output logic        MARLOAD,
  output logic        MBRLOAD,
  output logic        MFA,
  output logic        READ_WRITE,
  output logic        WORD_BYTE,
  input  logic        MFC,
  input  logic [31:0] mem_rdata
);

  localparam logic [1:0] c_IDLE = 2'd0;
  localparam logic [1:0] c_LOAD = 2'd1;
  localparam logic [1:0] c_WAIT = 2'd2;
  localparam logic [1:0] c_DONE = 2'd3;

  localparam int c_STREAK_W = (MAX_D_STREAK < 1) ? 1 : $clog2(MAX_D_STREAK + 1);
  localparam logic [c_STREAK_W-1:0] c_STREAK_MAX = c_STREAK_W'(MAX_D_STREAK);
  localparam logic [c_STREAK_W-1:0] c_STREAK_ONE = c_STREAK_W'(1);
  localparam logic [7:0]            c_WDOG_LAST  = 8'(TIMEOUT - 1);

  logic [1:0]            state_q, state_d;
  logic                  owner_q, owner_d;   // 1 = D owns the port
  logic [31:0]           addr_q, addr_d;
  logic                  rw_q, rw_d;
  logic                  wb_q, wb_d;
  logic [31:0]           mbr_q, mbr_d;
  logic [31:0]           rdata_q, rdata_d;
  logic [c_STREAK_W-1:0] streak_q, streak_d;
  logic [7:0]            wdog_q, wdog_d;
  logic                  abort_q, abort_d;
  logic                  grant_d;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q  <= c_IDLE;
      owner_q  <= 1'b0;
      addr_q   <= '0;
      rw_q     <= 1'b0;
      wb_q     <= 1'b0;
      mbr_q    <= '0;
      rdata_q  <= '0;
      streak_q <= '0;
      wdog_q   <= '0;
      abort_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      addr_q   <= addr_d;
      rw_q     <= rw_d;
      wb_q     <= wb_d;
      mbr_q    <= mbr_d;
      rdata_q  <= rdata_d;
      streak_q <= streak_d;
      wdog_q   <= wdog_d;
      abort_q  <= abort_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    addr_d   = addr_q;
    rw_d     = rw_q;
    wb_d     = wb_q;
    mbr_d    = mbr_q;
    rdata_d  = rdata_q;
    streak_d = streak_q;
    wdog_d   = wdog_q;
    abort_d  = abort_q;
    grant_d  = 1'b0;
    case (state_q)
      c_IDLE: begin
        if (f_req || d_req) begin
          // D wins ties until it has starved a pending F for MAX_D_STREAK grants
          grant_d = d_req && (!f_req || (streak_q != c_STREAK_MAX));
          abort_d = 1'b0;
          state_d = c_LOAD;
          if (grant_d) begin
            owner_d = 1'b1;
            addr_d  = d_addr;
            rw_d    = d_rw;
            wb_d    = d_word_byte;
            if (!d_rw) mbr_d = d_wdata;
            if (!f_req)                         streak_d = '0;
            else if (streak_q != c_STREAK_MAX)  streak_d = streak_q + c_STREAK_ONE;
          end else begin
            owner_d  = 1'b0;
            addr_d   = f_addr;
            rw_d     = 1'b1;
            wb_d     = 1'b1;
            streak_d = '0;
          end
        end
      end
      c_LOAD: begin
        wdog_d  = '0;
        state_d = c_WAIT;
      end
      c_WAIT: begin
        if (MFC) begin
          if (rw_q) rdata_d = mem_rdata;
          state_d = c_DONE;
        end else if (wdog_q == c_WDOG_LAST) begin
          abort_d = 1'b1;
          state_d = c_DONE;
        end else begin
          wdog_d = wdog_q + 8'd1;
        end
      end
      c_DONE:  state_d = c_IDLE;
      default: state_d = c_IDLE;
    endcase
  end

  always_comb begin
    MARLOAD    = 1'b0;
    MBRLOAD    = 1'b0;
    MFA        = 1'b0;
    READ_WRITE = 1'b0;
    WORD_BYTE  = 1'b0;
    f_done     = 1'b0;
    d_done     = 1'b0;
    err        = 1'b0;
    busy       = (state_q != c_IDLE);
    case (state_q)
      c_LOAD: begin
        MARLOAD    = 1'b1;
        MBRLOAD    = !rw_q;
        READ_WRITE = rw_q;
        WORD_BYTE  = wb_q;
      end
      c_WAIT: begin
        MFA        = 1'b1;
        READ_WRITE = rw_q;
        WORD_BYTE  = wb_q;
      end
      c_DONE: begin
        f_done = !owner_q;
        d_done = owner_q;
        err    = abort_q;
      end
      default: ;
    endcase
  end

  assign rdata   = rdata_q;
  assign mar_out = addr_q;
  assign mbr_out = mbr_q;

endmodule

`default_nettype wire
